// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: mode codes and FSM encodings shared by the
// Gray/binary conversion arbiter and its round-robin picker.
package gray_conv_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/gray_conv_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker; the first
// set request at or after ptr (with wrap) wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any_req
);

  int             pos;
  logic [IDW-1:0] cand;
  logic           found;

  // scan from ptr upward, wrapping, and keep the first hit
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      pos  = (int'(ptr) + off) % NREQ;
      cand = IDW'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: one shared bin2gray/gray2bin engine behind a
// round-robin arbiter. Macro GRAY_CONV_PARALLEL_G2B_EN: one-cycle gray2bin.
import gray_conv_pkg::*;

module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  rsp_ready,
  output logic                  busy
);

  state_t state;
  state_t state_nx;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   idx;
  logic             any_req;
  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] win_data;
  logic             win_mode;
  logic [WIDTH-1:0] b2g_w;
  logic             accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .idx     (idx),
    .any_req (any_req)
  );

  assign win_data  = req_data[idx*WIDTH +: WIDTH];
  assign win_mode  = req_mode[idx];
  assign b2g_w     = win_data ^ (win_data >> 1);
  assign accept    = (state == ST_IDLE) && any_req;
  assign req_ready = (state == ST_IDLE) ? gnt : '0;
  assign rsp_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

`ifdef GRAY_CONV_PARALLEL_G2B_EN
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`else
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] gword;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_up;
  logic             last_bit;

  assign cnt_up   = cnt + 1'b1;
  assign last_bit = (state == ST_BUSY) && (cnt == '0);

  // resolve one more binary bit below the ones already known
  always_comb begin
    acc_nx      = acc;
    acc_nx[cnt] = acc[cnt_up] ^ gword[cnt];
  end

  // serial gray2bin working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      gword <= '0;
      cnt   <= '0;
    end else if (accept) begin
      acc   <= {win_data[WIDTH-1], {(WIDTH-1){1'b0}}};
      gword <= win_data;
      cnt   <= CW'(WIDTH-2);
    end else if (state == ST_BUSY) begin
      acc   <= acc_nx;
      cnt   <= cnt - 1'b1;
    end
  end
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
`ifdef GRAY_CONV_PARALLEL_G2B_EN
          state_nx = ST_HOLD;
`else
          state_nx = (win_mode == MODE_G2B) ? ST_BUSY : ST_HOLD;
`endif
        end
      end
      ST_BUSY: begin
`ifdef GRAY_CONV_PARALLEL_G2B_EN
        state_nx = ST_HOLD;
`else
        if (cnt == '0) state_nx = ST_HOLD;
`endif
      end
      ST_HOLD: begin
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // round-robin pointer moves just past each winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (idx == IDW'(NREQ-1)) ? '0 : idx + 1'b1;
    end
  end

  // response register: loaded at accept or when serial resolve ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (accept) begin
      rsp_id <= idx;
      if (win_mode == MODE_B2G) begin
        rsp_data <= b2g_w;
      end
`ifdef GRAY_CONV_PARALLEL_G2B_EN
      else begin
        rsp_data <= g2b(win_data);
      end
`endif
    end
`ifndef GRAY_CONV_PARALLEL_G2B_EN
    else if (last_bit) begin
      rsp_data <= acc_nx;
    end
`endif
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed and randomized checks of the shared
// converter against a transaction-level reference model.
module tb_gray_conv_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
`ifdef GRAY_CONV_PARALLEL_G2B_EN
  localparam int G2B_LAT = 1;
`else
  localparam int G2B_LAT = WIDTH;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_ready;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;

  gray_conv_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_b2g(input int d);
    return d ^ (d >> 1);
  endfunction

  // binary bit i is the parity of all Gray bits at or above i
  function automatic int ref_g2b(input int g);
    int b = 0;
    for (int i = 0; i < WIDTH; i++)
      if (($countones(g >> i) % 2) == 1) b |= (1 << i);
    return b;
  endfunction

  function automatic int ref_winner(input logic [NREQ-1:0] v,
                                    input int ptr);
    for (int off = 0; off < NREQ; off++)
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  task automatic scramble();
    req_valid = NREQ'($urandom);
    req_mode  = NREQ'($urandom);
    req_data  = (NREQ*WIDTH)'($urandom);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_mode  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ptr = 0;
  endtask

  task automatic do_txn(input  logic [NREQ-1:0]       v,
                        input  logic [NREQ-1:0]       m,
                        input  logic [NREQ*WIDTH-1:0] d,
                        input  int                    stall,
                        output logic [WIDTH-1:0]      got,
                        output logic [IDW-1:0]        gid);
    int g;
    int lat;
    int word;
    int exp_d;
    req_valid = v;
    req_mode  = m;
    req_data  = d;
    g     = ref_winner(v, m_ptr);
    word  = int'(d[g*WIDTH +: WIDTH]);
    exp_d = m[g] ? ref_g2b(word) : ref_b2g(word);
    lat   = m[g] ? G2B_LAT : 1;
    @(negedge clk);
    check("grant", req_ready, 1 << g);
    check("idle_busy", busy, 0);
    check("idle_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    m_ptr = (g + 1) % NREQ;
    for (int c = 1; c < lat; c++) begin
      scramble();
      rsp_ready = 1'(($urandom));
      @(negedge clk);
      check("wait_busy", busy, 1);
      check("wait_valid", rsp_valid, 0);
      check("wait_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < stall; c++) begin
      scramble();
      req_valid = '1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, exp_d);
      check("stall_id", rsp_id, g);
      check("stall_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    scramble();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, exp_d);
    check("rsp_id", rsp_id, g);
    check("hold_ready", req_ready, 0);
    got = rsp_data;
    gid = rsp_id;
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  logic [WIDTH-1:0] got;
  logic [WIDTH-1:0] back;
  logic [IDW-1:0]   gid;
  int               slot;
  logic [NREQ-1:0]  rv;

  initial begin
    req_valid = '0;
    req_mode  = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    #3;
    do_reset();

    do_txn(4'b0001, 4'b0000, 16'h0006, 0, got, gid);
    check("t1_data", got, 4'b0101);
    check("t1_id", gid, 0);

    do_txn(4'b0010, 4'b0010, 16'h00F0, 0, got, gid);
    check("t2_data", got, 4'b1010);
    check("t2_id", gid, 1);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 4'b0000, 16'h3210, 0, got, gid);
      check("t3_id", gid, i % NREQ);
      check("t3_data", got, (i % NREQ) ^ ((i % NREQ) >> 1));
    end

    do_txn(4'b1111, 4'b0000, 16'h3210, 5, got, gid);
    check("t4_id", gid, 1);
    do_txn(4'b1111, 4'b0000, 16'h3210, 0, got, gid);
    check("t4_next", gid, 2);

    req_valid = 4'b0010;
    req_mode  = 4'b0010;
    req_data  = (NREQ*WIDTH)'($urandom);
    @(negedge clk);
    check("t5_grant", req_ready, 1 << ref_winner(4'b0010, m_ptr));
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("t5_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", rsp_valid, 0);
    check("t5_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ptr = 0;
    do_txn(4'b1100, 4'b0000, 16'h5A00, 0, got, gid);
    check("t5_id", gid, 2);

    for (int v = 0; v < (1 << WIDTH); v++) begin
      slot = int'($urandom_range(0, NREQ-1));
      rv   = NREQ'(1 << slot);
      do_txn(rv, 4'b0000, (NREQ*WIDTH)'(v << (slot*WIDTH)), 0,
             got, gid);
      slot = int'($urandom_range(0, NREQ-1));
      rv   = NREQ'(1 << slot);
      do_txn(rv, rv, (NREQ*WIDTH)'(int'(got) << (slot*WIDTH)), 0,
             back, gid);
      check("t6_roundtrip", back, v);
    end

    for (int n = 0; n < 60; n++) begin
      for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
        req_valid = '0;
        req_mode  = NREQ'($urandom);
        req_data  = (NREQ*WIDTH)'($urandom);
        rsp_ready = 1'(($urandom));
        @(negedge clk);
        check("gap_ready", req_ready, 0);
        check("gap_busy", busy, 0);
        @(posedge clk);
        #1;
      end
      rv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_txn(rv, NREQ'($urandom), (NREQ*WIDTH)'($urandom),
             int'($urandom_range(0, 3)), got, gid);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
